// File: rtl/mipi_rx_if.sv
// Receive-side bundle for mipi_frame_receiver: beat stream in, payload handshake,
// error pulses and statistics out. "slave" is the receiver, "master" its environment.
interface mipi_rx_if #(
    parameter int DLEN  = 6,
    parameter int CNT_W = 16
);
    logic [47:0]        packet;
    logic               my_mipi_rx_VALID;
    logic               data_ready;
    logic [DLEN*8-1:0]  data;
    logic               data_valid;
    logic [23:0]        pkt_id;
    logic [7:0]         dtype;
    logic               err_len;
    logic               err_timeout;
    logic               err_crc;
    logic [CNT_W-1:0]   frame_count;
    logic [CNT_W-1:0]   drop_count;

    modport master (
        output packet, my_mipi_rx_VALID, data_ready,
        input  data, data_valid, pkt_id, dtype,
        input  err_len, err_timeout, err_crc, frame_count, drop_count
    );

    modport slave (
        input  packet, my_mipi_rx_VALID, data_ready,
        output data, data_valid, pkt_id, dtype,
        output err_len, err_timeout, err_crc, frame_count, drop_count
    );
endinterface

// File: rtl/mipi_frame_receiver.sv
// Frame receiver: SOF beat, header beat, N payload beats (optional checksum beat), then hold
// until accepted. Define RX_CHECKSUM_EN to build the CSUM state and XOR accumulator.
module mipi_frame_receiver #(
    parameter int          DLEN    = 6,
    parameter logic [23:0] SOF     = 24'hEAFF99,
    parameter int          TIMEOUT = 255,
    parameter int          CNT_W   = 16
) (
    input  logic     rx_pixel_clk,
    input  logic     rx_reset,
    mipi_rx_if.slave rx
);
    localparam int               DW        = DLEN * 8;
    localparam logic [15:0]      IDLE_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

`ifdef RX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CSUM, HOLD} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, HOLD} state_t;
`endif

    state_t           state_reg, state_next;
    logic [DW-1:0]    data_reg, data_next;
    logic [23:0]      pkt_id_reg, pkt_id_next;
    logic [7:0]       dtype_reg, dtype_next;
    logic [6:0]       rem_reg, rem_next;
    logic [15:0]      idle_reg, idle_next;
    logic [CNT_W-1:0] frame_cnt_reg, drop_cnt_reg;
    logic             err_len_reg, err_len_next;
    logic             err_to_reg, err_to_next;
    logic             frame_inc, drop_inc;

    logic        valid;
    logic [47:0] pkt;
    logic        is_sof;
    logic [31:0] hdr_dlen;
    logic        dlen_bad;
    logic [6:0]  nbeats;
    logic        idle_expired;
    logic [47:0] beat_swap;
    logic [DW-1:0] data_shift;

    assign valid        = rx.my_mipi_rx_VALID;
    assign pkt          = rx.packet;
    assign is_sof       = (pkt[47:24] == SOF);
    assign hdr_dlen     = pkt[39:8];
    assign dlen_bad     = (hdr_dlen == 32'd0) || (hdr_dlen > 32'(DLEN));
    // Only meaningful once dlen_bad is clear, so dlen <= 64 and 7 bits suffice.
    assign nbeats       = (hdr_dlen[6:0] + 7'd5) / 7'd6;
    assign idle_expired = !valid && (idle_reg == IDLE_LAST);
    assign beat_swap    = {pkt[23:0], pkt[47:24]};

    // Older beats move towards the MSB; anything beyond DLEN bytes falls off the top.
    generate
        if (DW > 48) begin : g_wide
            assign data_shift = {data_reg[DW-49:0], beat_swap};
        end else if (DW == 48) begin : g_exact
            assign data_shift = beat_swap;
        end else begin : g_narrow
            assign data_shift = beat_swap[DW-1:0];
        end
    endgenerate

`ifdef RX_CHECKSUM_EN
    logic [7:0] csum_reg, csum_next;
    logic       err_crc_reg, err_crc_next;
    logic [7:0] byte_xor [0:6];

    assign byte_xor[0] = 8'h00;
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_byte_xor
            assign byte_xor[gi+1] = byte_xor[gi] ^ pkt[gi*8 +: 8];
        end
    endgenerate
`endif

    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        pkt_id_next  = pkt_id_reg;
        dtype_next   = dtype_reg;
        rem_next     = rem_reg;
        idle_next    = idle_reg;
        err_len_next = 1'b0;
        err_to_next  = 1'b0;
        frame_inc    = 1'b0;
        drop_inc     = 1'b0;
`ifdef RX_CHECKSUM_EN
        csum_next    = csum_reg;
        err_crc_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (valid && is_sof) begin
                    pkt_id_next = pkt[23:0];
                    data_next   = '0;
                    idle_next   = 16'd0;
`ifdef RX_CHECKSUM_EN
                    csum_next   = 8'h00;
`endif
                    state_next  = HDR;
                end
            end
            HDR: begin
                if (valid) begin
                    dtype_next = pkt[47:40];
                    idle_next  = 16'd0;
                    if (dlen_bad) begin
                        err_len_next = 1'b1;
                        drop_inc     = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        rem_next   = nbeats;
                        state_next = PAYLOAD;
                    end
                end else if (idle_expired) begin
                    err_to_next = 1'b1;
                    drop_inc    = 1'b1;
                    state_next  = IDLE;
                end else begin
                    idle_next = idle_reg + 16'd1;
                end
            end
            PAYLOAD: begin
                if (valid) begin
                    data_next = data_shift;
                    idle_next = 16'd0;
                    rem_next  = rem_reg - 7'd1;
`ifdef RX_CHECKSUM_EN
                    csum_next = csum_reg ^ byte_xor[6];
                    if (rem_reg == 7'd1) state_next = CSUM;
`else
                    if (rem_reg == 7'd1) state_next = HOLD;
`endif
                end else if (idle_expired) begin
                    err_to_next = 1'b1;
                    drop_inc    = 1'b1;
                    state_next  = IDLE;
                end else begin
                    idle_next = idle_reg + 16'd1;
                end
            end
`ifdef RX_CHECKSUM_EN
            CSUM: begin
                if (valid) begin
                    idle_next = 16'd0;
                    if (pkt[7:0] == csum_reg) begin
                        state_next = HOLD;
                    end else begin
                        err_crc_next = 1'b1;
                        drop_inc     = 1'b1;
                        state_next   = IDLE;
                    end
                end else if (idle_expired) begin
                    err_to_next = 1'b1;
                    drop_inc    = 1'b1;
                    state_next  = IDLE;
                end else begin
                    idle_next = idle_reg + 16'd1;
                end
            end
`endif
            HOLD: begin
                // Beats are not consumed here; a new SOF means that frame is lost.
                if (valid && is_sof) drop_inc = 1'b1;
                if (rx.data_ready) begin
                    frame_inc  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rx_pixel_clk or posedge rx_reset) begin
        if (rx_reset) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            pkt_id_reg    <= '0;
            dtype_reg     <= '0;
            rem_reg       <= '0;
            idle_reg      <= '0;
            frame_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
            err_len_reg   <= 1'b0;
            err_to_reg    <= 1'b0;
`ifdef RX_CHECKSUM_EN
            csum_reg      <= '0;
            err_crc_reg   <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            pkt_id_reg  <= pkt_id_next;
            dtype_reg   <= dtype_next;
            rem_reg     <= rem_next;
            idle_reg    <= idle_next;
            err_len_reg <= err_len_next;
            err_to_reg  <= err_to_next;
`ifdef RX_CHECKSUM_EN
            csum_reg    <= csum_next;
            err_crc_reg <= err_crc_next;
`endif
            if (frame_inc && (frame_cnt_reg != CNT_MAX)) frame_cnt_reg <= frame_cnt_reg + 1'b1;
            if (drop_inc && (drop_cnt_reg != CNT_MAX))   drop_cnt_reg  <= drop_cnt_reg + 1'b1;
        end
    end

    assign rx.data        = data_reg;
    assign rx.data_valid  = (state_reg == HOLD);
    assign rx.pkt_id      = pkt_id_reg;
    assign rx.dtype       = dtype_reg;
    assign rx.err_len     = err_len_reg;
    assign rx.err_timeout = err_to_reg;
    assign rx.frame_count = frame_cnt_reg;
    assign rx.drop_count  = drop_cnt_reg;
`ifdef RX_CHECKSUM_EN
    assign rx.err_crc     = err_crc_reg;
`else
    assign rx.err_crc     = 1'b0;
`endif
endmodule

// File: tb/tb_mipi_frame_receiver.sv
// Scoreboard bench for mipi_frame_receiver: directed frames push expected events,
// a negedge monitor pops and compares on every handshake or error pulse.
module tb_mipi_frame_receiver;
    localparam int K_FRAME = 0, K_LEN = 1, K_TO = 2, K_CRC = 3;

    typedef struct {
        int          kind;
        logic [47:0] data;
        logic [23:0] id;
        logic [7:0]  dt;
        logic [15:0] drop;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mipi_rx_if #(.DLEN(6), .CNT_W(16)) bus ();

    mipi_frame_receiver #(.DLEN(6), .SOF(24'hEAFF99), .TIMEOUT(255), .CNT_W(16)) dut (
        .rx_pixel_clk (clk),
        .rx_reset     (rst),
        .rx           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("check %s ok: 0x%0h", name, act);
        end
    endtask

    function automatic void observe(input int kind);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d, expected none", kind);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind) begin
            errors++;
            $display("FAIL event_kind: got %0d, expected %0d", kind, e.kind);
        end else if (kind == K_FRAME &&
                     (bus.data !== e.data || bus.pkt_id !== e.id || bus.dtype !== e.dt)) begin
            errors++;
            $display("FAIL frame: got data=0x%0h id=0x%0h dt=0x%0h, expected data=0x%0h id=0x%0h dt=0x%0h",
                     bus.data, bus.pkt_id, bus.dtype, e.data, e.id, e.dt);
        end else if (kind != K_FRAME && bus.drop_count !== e.drop) begin
            errors++;
            $display("FAIL err_drop_count: got %0d, expected %0d (kind %0d)", bus.drop_count, e.drop, kind);
        end else begin
            $display("event kind %0d ok: data=0x%0h id=0x%0h drop=%0d", kind, bus.data, bus.pkt_id, bus.drop_count);
        end
    endfunction

    // Monitor: every visible handshake or error pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (int'(bus.err_len) + int'(bus.err_timeout) + int'(bus.err_crc) > 1) begin
                errors++;
                $display("FAIL err_exclusive: got len=%0b to=%0b crc=%0b, expected at most one",
                         bus.err_len, bus.err_timeout, bus.err_crc);
            end
            if (bus.data_valid && bus.data_ready) observe(K_FRAME);
            if (bus.err_len)     observe(K_LEN);
            if (bus.err_timeout) observe(K_TO);
            if (bus.err_crc)     observe(K_CRC);
        end
    end

    function automatic logic [7:0] xor6(input logic [47:0] p);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 6; i++) x = x ^ p[i*8 +: 8];
        return x;
    endfunction

    task automatic push(input int kind, input logic [47:0] d, input logic [23:0] id,
                        input logic [7:0] dt, input logic [15:0] drop);
        exp_t e;
        e.kind = kind; e.data = d; e.id = id; e.dt = dt; e.drop = drop;
        sb.push_back(e);
    endtask

    task automatic send(input logic [47:0] p);
        bus.packet           = p;
        bus.my_mipi_rx_VALID = 1'b1;
        @(posedge clk);
        #1;
        bus.my_mipi_rx_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.my_mipi_rx_VALID = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hdr(input logic [7:0] dt, input logic [31:0] dlen);
        send({dt, dlen, 8'h00});
    endtask

    task automatic tail(input logic [47:0] payload);
        send(payload);
`ifdef RX_CHECKSUM_EN
        send({40'h0, xor6(payload)});
`endif
    endtask

    task automatic send_frame(input logic [23:0] id, input logic [7:0] dt, input logic [31:0] dlen,
                              input logic [47:0] payload, input logic [47:0] exp_data);
        push(K_FRAME, exp_data, id, dt, 16'd0);
        send({24'hEAFF99, id});
        hdr(dt, dlen);
        tail(payload);
    endtask

    initial begin
        int found;
        bus.packet = '0;
        bus.my_mipi_rx_VALID = 1'b0;
        bus.data_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_valid", 64'(bus.data_valid), 64'd0);
        chk("rst_data", 64'(bus.data), 64'd0);
        chk("rst_pkt_id", 64'(bus.pkt_id), 64'd0);
        chk("rst_counts", {bus.frame_count, bus.drop_count, bus.dtype}, 64'd0);
        chk("rst_errs", {bus.err_len, bus.err_timeout, bus.err_crc}, 64'd0);
        rst = 1'b0;

        // Basic frame, SOF on the first edge after reset release.
        bus.data_ready = 1'b1;
        send_frame(24'h000001, 8'h00, 32'd6, 48'hAABBCC112233, 48'h112233AABBCC);
        chk("latency_valid", 64'(bus.data_valid), 64'd1);
        idle(1);
        chk("one_valid_cycle", 64'(bus.data_valid), 64'd0);
        chk("frame_count_1", 64'(bus.frame_count), 64'd1);

        // Bad lengths: one above DLEN and zero.
        push(K_LEN, 48'h0, 24'h0, 8'h0, 16'd1);
        send({24'hEAFF99, 24'h000002});
        hdr(8'h12, 32'd7);
        idle(1);
        chk("len_no_valid", 64'(bus.data_valid), 64'd0);
        push(K_LEN, 48'h0, 24'h0, 8'h0, 16'd2);
        send({24'hEAFF99, 24'h000002});
        hdr(8'h12, 32'd0);
        idle(1);
        chk("drop_after_len", 64'(bus.drop_count), 64'd2);

        // Smallest legal length still shifts a full beat.
        send_frame(24'h00ABCD, 8'h2B, 32'd1, 48'h010203040506, 48'h040506010203);
        idle(2);
        chk("frame_count_2", 64'(bus.frame_count), 64'd2);

        // Timeout must fire on exactly the 255th idle cycle after the header.
        push(K_TO, 48'h0, 24'h0, 8'h0, 16'd3);
        send({24'hEAFF99, 24'h000003});
        hdr(8'h00, 32'd6);
        found = 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (bus.err_timeout) begin
                found = n;
                break;
            end
        end
        chk("timeout_cycle", 64'(found), 64'd255);
        idle(2);
        chk("drop_after_timeout", 64'(bus.drop_count), 64'd3);

        // Valid beats restart the idle count: 200 + 200 idle cycles must not time out.
        push(K_FRAME, 48'h0D0E0F0A0B0C, 24'h00C0DE, 8'h21, 16'd0);
        send({24'hEAFF99, 24'h00C0DE});
        idle(200);
        hdr(8'h21, 32'd6);
        idle(200);
        tail(48'h0A0B0C0D0E0F);
        idle(2);
        chk("frame_count_3", 64'(bus.frame_count), 64'd3);

        // Backpressure with a second SOF arriving while held.
        bus.data_ready = 1'b0;
        send_frame(24'h000004, 8'h33, 32'd6, 48'hEAFF99000005, 48'h000005EAFF99);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) send({24'hEAFF99, 24'h000005});
            else if (i == 5) send(48'h123456789ABC);
            else idle(1);
            if (bus.data !== 48'h000005EAFF99 || !bus.data_valid) begin
                errors++;
                $display("FAIL hold_stable: got data=0x%0h valid=%0b, expected data=0x000005eaff99 valid=1",
                         bus.data, bus.data_valid);
            end
            checks++;
        end
        chk("drop_after_hold_sof", 64'(bus.drop_count), 64'd4);
        bus.data_ready = 1'b1;
        idle(1);
        chk("frame_count_4", 64'(bus.frame_count), 64'd4);

`ifdef RX_CHECKSUM_EN
        push(K_FRAME, 48'h040506010203, 24'h000010, 8'h00, 16'd0);
        send({24'hEAFF99, 24'h000010});
        hdr(8'h00, 32'd6);
        send(48'h010203040506);
        send({40'h0, 8'h07});
        idle(2);
        chk("csum_ok_frames", 64'(bus.frame_count), 64'd5);
        push(K_CRC, 48'h0, 24'h0, 8'h0, 16'd5);
        send({24'hEAFF99, 24'h000011});
        hdr(8'h00, 32'd6);
        send(48'h010203040506);
        send({40'h0, 8'h00});
        chk("csum_bad_no_valid", 64'(bus.data_valid), 64'd0);
        idle(2);
`endif

        // Reset in PAYLOAD abandons the frame and clears everything at once.
        send({24'hEAFF99, 24'h000006});
        hdr(8'h55, 32'd6);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {15'd0, bus.data_valid, bus.data}, 64'd0);
        chk("mid_rst_counts", {bus.pkt_id, bus.frame_count, bus.drop_count}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(24'h000007, 8'h44, 32'd6, 48'h123456789ABC, 48'h789ABC123456);
        idle(2);
        chk("post_rst_counts", {bus.frame_count, bus.drop_count}, 64'h0000_0001_0000);

        idle(3);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mipi_frame_receiver.md
MIPI_FRAME_RECEIVER -- requirements
Module: mipi_frame_receiver

Interface
REQ-001 Parameter DLEN, default 6, maximum payload bytes per frame; legal values are 1..64.
REQ-002 Parameter SOF, default 24'hEAFF99, start-of-frame pattern.
REQ-003 Parameter TIMEOUT, default 255, idle-beat limit inside a frame; legal values are 1..65535.
REQ-004 Parameter CNT_W, default 16, statistics counter width.
REQ-005 rx_pixel_clk  in  1  sole clock; all logic is clocked on its rising edge.
REQ-006 rx_reset  in  1  reset, asynchronous and active-high.
REQ-007 packet  in  48  receive beat; byte 0 is [47:40].
REQ-008 my_mipi_rx_VALID  in  1  beat qualifier; the block consumes a beat only when this is 1.
REQ-009 data_ready  in  1  downstream accepts the payload.
REQ-010 data  out  DLEN*8  assembled payload.
REQ-011 data_valid  out  1  payload available; held until accepted.
REQ-012 pkt_id  out  24  header ID of the frame currently held in data.
REQ-013 dtype  out  8  data type of the held frame.
REQ-014 err_len  out  1  one-cycle pulse for a bad dlen.
REQ-015 err_timeout  out  1  one-cycle pulse for a frame timeout.
REQ-016 err_crc  out  1  one-cycle pulse for a checksum mismatch.
REQ-017 frame_count  out  CNT_W  frames delivered; saturates at all-ones.
REQ-018 drop_count  out  CNT_W  frames lost for any reason; saturates at all-ones.

Function
REQ-019 The state machine SHALL have the states IDLE, HDR, PAYLOAD, CSUM and HOLD.
REQ-020 IDLE: a valid beat with packet[47:24]==SOF SHALL capture pkt_id from [23:0], clear data, and move to HDR; any other beat is discarded.
REQ-021 HDR: the next valid beat SHALL capture dtype from [47:40], dlen from [39:8] (32 bits) and phl_id from [7:0].
REQ-022 HDR: when dlen==0 or dlen>DLEN, the block SHALL pulse err_len, increment drop_count and return to IDLE; otherwise it moves to PAYLOAD with beat count N=ceil(dlen/6).
REQ-023 PAYLOAD: each valid beat SHALL update data to (data<<48)|{packet[23:0],packet[47:24]}, truncated to DLEN*8 bits.
REQ-024 PAYLOAD: after the Nth valid payload beat the block SHALL move to CSUM if RX_CHECKSUM_EN is defined, and to HOLD otherwise.
REQ-025 HOLD: the block SHALL assert data_valid, with data, pkt_id and dtype held stable.
REQ-026 HOLD: when data_valid and data_ready are both 1 at a clock edge, the frame transfers, frame_count increments, and the next state is IDLE.
REQ-027 Latency: data_valid SHALL rise on the clock edge that consumes the final beat of the frame.
REQ-028 HOLD: incoming beats SHALL be ignored; each valid SOF beat seen in HOLD SHALL increment drop_count.
REQ-029 Timeout: in HDR, PAYLOAD or CSUM, TIMEOUT consecutive cycles with VALID=0 SHALL pulse err_timeout, increment drop_count and return to IDLE; any valid beat clears the idle counter.
REQ-030 A SOF pattern received inside PAYLOAD SHALL be treated as payload; frames do not resynchronise mid-frame.
REQ-031 Counter saturation: a counter at all-ones SHALL stay at all-ones and SHALL NOT wrap.
REQ-032 The err_* pulses SHALL be mutually exclusive and last exactly one cycle.

Reset
REQ-033 While rx_reset=1, the block SHALL be in state IDLE.
REQ-034 While rx_reset=1, data, pkt_id, dtype and both counters SHALL be 0.
REQ-035 While rx_reset=1, data_valid and all err_* outputs SHALL be 0, and the idle counter and checksum accumulator SHALL be cleared.
REQ-036 A reset asserted mid-frame or in HOLD SHALL abandon the frame without incrementing drop_count.
REQ-037 The block SHALL accept a SOF beat on the first edge after rx_reset deasserts.

Configuration
REQ-038 When RX_CHECKSUM_EN is defined, the block SHALL keep a running XOR of all 6*N payload bytes.
REQ-039 When RX_CHECKSUM_EN is defined, CSUM SHALL consume one valid beat and compare its [7:0] with the accumulated XOR.
REQ-040 When RX_CHECKSUM_EN is defined and the checksum matches, the block SHALL move to HOLD.
REQ-041 When RX_CHECKSUM_EN is defined and the checksum mismatches, the block SHALL pulse err_crc, increment drop_count and return to IDLE without asserting data_valid.
REQ-042 When RX_CHECKSUM_EN is undefined, the CSUM state and the accumulator SHALL NOT be built, and err_crc SHALL be tied to 0.

Verification
REQ-043 With DLEN=6, send SOF|000001, then 00_00000006_00, then payload 0xAABBCC112233 with data_ready=1 -> data=0x112233AABBCC, pkt_id=0x000001, one data_valid cycle, frame_count=1.
REQ-044 Send a header with dlen=7 and DLEN=6 -> err_len pulse, drop_count=1, state IDLE, no data_valid.
REQ-045 Hold VALID=0 for 255 cycles after a header with TIMEOUT=255 -> err_timeout pulse on cycle 255, drop_count increments.
REQ-046 Complete a frame with data_ready=0 for 10 cycles while a second SOF arrives -> data stays stable, drop_count=1; after ready rises, frame_count=1.
REQ-047 With RX_CHECKSUM_EN defined, send payload 0x010203040506 and checksum beat [7:0]=0x07 -> data_valid asserts; with [7:0]=0x00 instead -> err_crc pulse and no data_valid.
REQ-048 Assert rx_reset in PAYLOAD -> all outputs 0 immediately, drop_count unchanged, and the next frame is received correctly.
